// File: rtl/starfield_scroll.sv
// starfield_scroll: pixel-rate starfield generator.
// A 21-bit Galois LFSR (x^21 + x^19 + 1) advances once per enabled pixel and is
// reloaded from SEED at the end of every period. The period is the frame size
// plus a signed per-frame drift, so the star pattern slides sideways by the
// drift amount each frame. Outputs are registered and aligned with a delayed de.
// Optional feature: define STARFIELD_TWINKLE_EN to add a per-frame counter that
// offsets star brightness, which makes stars twinkle without moving them.

module starfield_scroll #(
    parameter int unsigned H_RES_TOT = 800,
    parameter int unsigned V_RES_TOT = 525,
    parameter logic [20:0] SEED      = 21'h1,
    parameter int unsigned DENS      = 8
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       en,
    input  logic       de,
    input  logic [7:0] step,
    output logic       sf_de,
    output logic       sf_on,
    output logic [7:0] sf_bright
);

    localparam int unsigned FrameTot  = H_RES_TOT * V_RES_TOT;
    localparam logic [20:0] FrameTotW = FrameTot[20:0];
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [20:0] SeedEff   = (SEED == 21'h0) ? 21'h1 : SEED;
    localparam logic [20:0] LfsrTaps  = 21'h140000;

    // Elaboration-time parameter sanity checks.
    if (DENS < 1 || DENS > 16) begin : g_dens_chk
        $error("starfield_scroll: DENS must be in 1..16");
    end
    if (FrameTot >= (32'd1 << 20) - 32'd128) begin : g_frame_chk
        $error("starfield_scroll: H_RES_TOT*V_RES_TOT too large for 20-bit counter");
    end

    logic [19:0] cnt_q, cnt_d;
    logic [20:0] lfsr_q, lfsr_d;
    logic [7:0]  step_q, step_d;
    logic [20:0] period;
    logic [20:0] last_cnt;
    logic        restart;
    logic        star;
    logic        hit;
    logic [7:0]  bright;

`ifdef STARFIELD_TWINKLE_EN
    logic [7:0]  frame_cnt_q, frame_cnt_d;
`endif

    // Period in force for this frame and the restart strobe (21-bit signed add).
    always_comb begin
        period   = FrameTotW + {{13{step_q[7]}}, step_q};
        last_cnt = period - 21'd1;
        restart  = ({1'b0, cnt_q} == last_cnt);
    end

    // Next state for counter, LFSR and latched drift; en low freezes all three.
    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        step_d = step_q;
        if (en) begin
            if (restart) begin
                cnt_d  = 20'd0;
                lfsr_d = SeedEff;
                step_d = step;
            end else begin
                cnt_d  = cnt_q + 20'd1;
                lfsr_d = {1'b0, lfsr_q[20:1]} ^ (lfsr_q[0] ? LfsrTaps : 21'h0);
            end
        end
    end

    // Counter, LFSR and drift state registers.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            cnt_q  <= 20'd0;
            lfsr_q <= SeedEff;
            step_q <= 8'd0;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            step_q <= step_d;
        end
    end

`ifdef STARFIELD_TWINKLE_EN
    // Frame counter bumps on each taken restart and wraps naturally at 8 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (en && restart) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    // Star decode from the current LFSR; on a restart cycle this is the pre-reload value.
    always_comb begin
        star = &lfsr_q[20 -: DENS];
        hit  = de & star;
`ifdef STARFIELD_TWINKLE_EN
        bright = lfsr_q[7:0] + frame_cnt_q;
`else
        bright = lfsr_q[7:0];
`endif
    end

    // Output stage updates every cycle, independent of en.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sf_de     <= 1'b0;
            sf_on     <= 1'b0;
            sf_bright <= 8'h00;
        end else begin
            sf_de     <= de;
            sf_on     <= hit;
            sf_bright <= hit ? bright : 8'h00;
        end
    end

endmodule

// File: tb/tb_starfield_scroll.sv
// Self-checking bench for starfield_scroll with an 8x4 frame (32 pixels),
// DENS=1 and SEED=1. A hand-computed table of LFSR states and star decodes per
// frame position drives all expectations.

module tb_starfield_scroll;

    localparam int FT = 32;

    logic       clk_pix;
    logic       rst_pix;
    logic       en;
    logic       de;
    logic [7:0] step;
    logic       sf_de;
    logic       sf_on;
    logic [7:0] sf_bright;

    starfield_scroll #(
        .H_RES_TOT(8),
        .V_RES_TOT(4),
        .SEED     (21'h1),
        .DENS     (1)
    ) dut (
        .clk_pix  (clk_pix),
        .rst_pix  (rst_pix),
        .en       (en),
        .de       (de),
        .step     (step),
        .sf_de    (sf_de),
        .sf_on    (sf_on),
        .sf_bright(sf_bright)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [20:0] lfsr;
        logic        on;
        logic [7:0]  bright;
    } vec_t;

    vec_t tab[0:34];

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_k      = 0;
    int   m_stepq  = 0;
    int   m_frame  = 0;
    bit   restarted;

    logic       cur_on[0:63];
    logic [7:0] cur_br[0:63];
    logic       f0_on[0:63];
    logic [7:0] f0_br[0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One pixel: drive inputs, clock, check outputs for the pre-edge state.
    task automatic pixel(input logic d, input logic e, input logic [7:0] s);
        int         k_now;
        logic       exp_on;
        logic [7:0] exp_br;
        logic [7:0] twk;
        de    = d;
        en    = e;
        step  = s;
        k_now = m_k;
`ifdef STARFIELD_TWINKLE_EN
        twk = 8'(m_frame);
`else
        twk = 8'd0;
`endif
        @(posedge clk_pix);
        #1;
        exp_on = d & tab[k_now].on;
        exp_br = exp_on ? tab[k_now].bright + twk : 8'h00;
        check("sf_de", {31'd0, sf_de}, {31'd0, d});
        check("sf_on", {31'd0, sf_on}, {31'd0, exp_on});
        check("sf_bright", {24'd0, sf_bright}, {24'd0, exp_br});
        cur_on[k_now] = sf_on;
        cur_br[k_now] = sf_bright;
        if (e) begin
            if (k_now == FT + m_stepq - 1) begin
                m_k       = 0;
                m_stepq   = int'($signed(s));
                m_frame++;
                restarted = 1'b1;
            end else begin
                m_k++;
            end
        end
        check("cnt", {12'd0, dut.cnt_q}, 32'(m_k));
        check("lfsr", {11'd0, dut.lfsr_q}, {11'd0, tab[m_k].lfsr});
    endtask

    // Run enabled pixels until the next restart; bounded at 64 pixels.
    task automatic run_frame(input logic d, input logic [7:0] s, output int len);
        len       = 0;
        restarted = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pixel(d, 1'b1, s);
            len++;
            if (restarted) break;
        end
        check("frame_bound", {31'd0, restarted}, 32'd1);
    endtask

    task automatic save_f0();
        for (int i = 0; i < 64; i++) begin
            f0_on[i] = cur_on[i];
            f0_br[i] = cur_br[i];
        end
    endtask

    function automatic int on_diffs(input int n);
        int dcount = 0;
        for (int i = 0; i < n; i++) begin
            if (cur_on[i] !== f0_on[i]) dcount++;
        end
        return dcount;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         len;
        logic [7:0] dbr;

        // LFSR states from seed 1 under x^21+x^19+1, with DENS=1 decode (bit 20).
        tab[0]  = '{21'h000001, 1'b0, 8'h00};
        tab[1]  = '{21'h140000, 1'b1, 8'h00};
        tab[2]  = '{21'h0A0000, 1'b0, 8'h00};
        tab[3]  = '{21'h050000, 1'b0, 8'h00};
        tab[4]  = '{21'h028000, 1'b0, 8'h00};
        tab[5]  = '{21'h014000, 1'b0, 8'h00};
        tab[6]  = '{21'h00A000, 1'b0, 8'h00};
        tab[7]  = '{21'h005000, 1'b0, 8'h00};
        tab[8]  = '{21'h002800, 1'b0, 8'h00};
        tab[9]  = '{21'h001400, 1'b0, 8'h00};
        tab[10] = '{21'h000A00, 1'b0, 8'h00};
        tab[11] = '{21'h000500, 1'b0, 8'h00};
        tab[12] = '{21'h000280, 1'b0, 8'h00};
        tab[13] = '{21'h000140, 1'b0, 8'h00};
        tab[14] = '{21'h0000A0, 1'b0, 8'h00};
        tab[15] = '{21'h000050, 1'b0, 8'h00};
        tab[16] = '{21'h000028, 1'b0, 8'h00};
        tab[17] = '{21'h000014, 1'b0, 8'h00};
        tab[18] = '{21'h00000A, 1'b0, 8'h00};
        tab[19] = '{21'h000005, 1'b0, 8'h00};
        tab[20] = '{21'h140002, 1'b1, 8'h02};
        tab[21] = '{21'h0A0001, 1'b0, 8'h00};
        tab[22] = '{21'h110000, 1'b1, 8'h00};
        tab[23] = '{21'h088000, 1'b0, 8'h00};
        tab[24] = '{21'h044000, 1'b0, 8'h00};
        tab[25] = '{21'h022000, 1'b0, 8'h00};
        tab[26] = '{21'h011000, 1'b0, 8'h00};
        tab[27] = '{21'h008800, 1'b0, 8'h00};
        tab[28] = '{21'h004400, 1'b0, 8'h00};
        tab[29] = '{21'h002200, 1'b0, 8'h00};
        tab[30] = '{21'h001100, 1'b0, 8'h00};
        tab[31] = '{21'h000880, 1'b0, 8'h00};
        tab[32] = '{21'h000440, 1'b0, 8'h00};
        tab[33] = '{21'h000220, 1'b0, 8'h00};
        tab[34] = '{21'h000110, 1'b0, 8'h00};

        // Reset held 3 cycles with de/en high: everything stays cleared.
        rst_pix = 1'b1;
        en      = 1'b1;
        de      = 1'b1;
        step    = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_pix);
            #1;
            check("rst_sf_de", {31'd0, sf_de}, 32'd0);
            check("rst_sf_on", {31'd0, sf_on}, 32'd0);
            check("rst_sf_bright", {24'd0, sf_bright}, 32'd0);
            check("rst_cnt", {12'd0, dut.cnt_q}, 32'd0);
            check("rst_lfsr", {11'd0, dut.lfsr_q}, 32'h1);
        end
        rst_pix = 1'b0;

        // Frames 0 and 1, static field: same star sequence, period 32.
        run_frame(1'b1, 8'd0, len);
        check("frame0_len", 32'(len), 32'd32);
        save_f0();
        run_frame(1'b1, 8'd0, len);
        check("frame1_len", 32'(len), 32'd32);
        check("static_repeat", 32'(on_diffs(32)), 32'd0);
        dbr = cur_br[20] - f0_br[20];
`ifdef STARFIELD_TWINKLE_EN
        check("twinkle_delta", {24'd0, dbr}, 32'd1);
`else
        check("static_bright", {24'd0, dbr}, 32'd0);
`endif

        // Drift +1: sampled at the end of frame 2, frame 3 runs 33 pixels.
        run_frame(1'b1, 8'd1, len);
        check("drift_pre_len", 32'(len), 32'd32);
        run_frame(1'b1, 8'd1, len);
        check("drift_pos_len", 32'(len), 32'd33);
        check("drift_pos_seq", 32'(on_diffs(32)), 32'd0);
        check("drift_pos_tail", {31'd0, cur_on[32]}, 32'd0);

        // Drift -1: frame 4 still 33, frame 5 shortened to 31.
        run_frame(1'b1, 8'hFF, len);
        check("drift_neg_pre_len", 32'(len), 32'd33);
        run_frame(1'b1, 8'hFF, len);
        check("drift_neg_len", 32'(len), 32'd31);
        check("drift_neg_seq", 32'(on_diffs(31)), 32'd0);

        // Back to step 0, then a mid-frame change to +3 at cnt=10.
        run_frame(1'b1, 8'd0, len);
        check("restore_len", 32'(len), 32'd31);
        for (int i = 0; i < 10; i++) pixel(1'b1, 1'b1, 8'd0);
        run_frame(1'b1, 8'd3, len);
        check("midstep_len", 32'(len + 10), 32'd32);
        run_frame(1'b1, 8'd0, len);
        check("midstep_next_len", 32'(len), 32'd35);

        // de held low for a full frame: outputs dark, state still advances.
        run_frame(1'b0, 8'd0, len);
        check("de_low_len", 32'(len), 32'd32);

        // en low for 5 cycles parked on a star: state frozen, output keeps decoding it.
        for (int i = 0; i < 20; i++) pixel(1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 5; i++) pixel(1'b1, 1'b0, 8'd0);
        check("en_low_cnt", {12'd0, dut.cnt_q}, 32'd20);
        run_frame(1'b1, 8'd0, len);
        check("en_low_resume_len", 32'(len + 20), 32'd32);

        // Mid-frame reset: aborts at once, pattern restarts from SEED.
        for (int i = 0; i < 13; i++) pixel(1'b1, 1'b1, 8'd5);
        rst_pix = 1'b1;
        #1;
        check("midrst_sf_on", {31'd0, sf_on}, 32'd0);
        check("midrst_sf_de", {31'd0, sf_de}, 32'd0);
        check("midrst_cnt", {12'd0, dut.cnt_q}, 32'd0);
        check("midrst_lfsr", {11'd0, dut.lfsr_q}, 32'h1);
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;
        m_k     = 0;
        m_stepq = 0;
        m_frame = 0;
        run_frame(1'b1, 8'd0, len);
        check("midrst_len", 32'(len), 32'd32);
        check("midrst_seq", 32'(on_diffs(32)), 32'd0);

`ifdef STARFIELD_TWINKLE_EN
        // Run until frame counter wraps 255 -> 0.
        for (int f = 0; f < 300 && m_frame < 255; f++) run_frame(1'b1, 8'd0, len);
        check("frame_cnt_255", {24'd0, dut.frame_cnt_q}, 32'd255);
        run_frame(1'b1, 8'd0, len);
        check("frame_cnt_wrap", {24'd0, dut.frame_cnt_q}, 32'd0);
        run_frame(1'b1, 8'd0, len);
        check("wrap_bright", {24'd0, cur_br[20]}, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
